// File: rtl/act_quant_stage.sv
// Output stage after the accumulator: optional ReLU, rounding right shift and signed saturation.
// Results go through a FIFO with an end-of-vector tag.
module act_quant_stage #(
    parameter int unsigned IDATAW = 32,
    parameter int unsigned ODATAW = 8,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned FDEPTH = 16,
    parameter int unsigned FADDRW = $clog2(FDEPTH),
    parameter int unsigned VECLEN = 64,
    parameter int unsigned VCNTW  = $clog2(VECLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [IDATAW-1:0] i_data,
    input  logic              i_relu,
    output logic              o_valid,
    output logic [ODATAW-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_almost_full,
    output logic              o_overflow
);

    localparam int unsigned CNTW = FADDRW + 1;
    localparam int unsigned HIW  = IDATAW - ODATAW + 2;
    localparam logic [IDATAW:0] RND = (IDATAW+1)'(1) << (SHIFT - 1);

    typedef struct packed {
        logic              last;
        logic [ODATAW-1:0] data;
    } entry_t;

    logic              s1_valid;
    logic [IDATAW-1:0] s1_data;
    logic              s2_valid;
    logic [ODATAW-1:0] s2_data;
    logic [VCNTW-1:0]  elem_cnt;

    entry_t            mem [FDEPTH];
    entry_t            head_c;
    logic [FADDRW-1:0] wr_ptr;
    logic [FADDRW-1:0] rd_ptr;
    logic [CNTW-1:0]   count;
    logic [CNTW-1:0]   count_nxt_c;

    logic signed [IDATAW:0] sum_c;
    logic signed [IDATAW:0] t_c;
    logic [HIW-1:0]         hi_c;
    logic [ODATAW-1:0]      q_c;

    logic push_c, pop_c, full_c, accept_c, drop_c, last_c;

    function automatic logic [FADDRW-1:0] ptr_inc(input logic [FADDRW-1:0] p);
        return (p == FADDRW'(FDEPTH - 1)) ? '0 : p + FADDRW'(1);
    endfunction

    // Rounding shift in IDATAW+1 bits, so the rounding add cannot overflow; saturate when the upper bits are not all sign bits.
    always_comb begin
        sum_c = $signed({s1_data[IDATAW-1], s1_data}) + $signed(RND);
        t_c   = sum_c >>> SHIFT;
        hi_c  = t_c[IDATAW:ODATAW-1];
        q_c   = t_c[ODATAW-1:0];
        if (!((&hi_c) || (~|hi_c))) begin
            q_c = t_c[IDATAW] ? {1'b1, {(ODATAW-1){1'b0}}} : {1'b0, {(ODATAW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid) s1_data <= (i_relu && i_data[IDATAW-1]) ? '0 : i_data;
        if (s1_valid) s2_data <= q_c;
    end

    // When the FIFO is full, a push is accepted only if a pop frees a slot on the same edge.
    always_comb begin
        full_c      = (count == CNTW'(FDEPTH));
        pop_c       = o_valid && i_ready;
        push_c      = s2_valid;
        accept_c    = push_c && (!full_c || pop_c);
        drop_c      = push_c && full_c && !pop_c;
        last_c      = (elem_cnt == VCNTW'(VECLEN - 1));
        count_nxt_c = count;
        case ({accept_c, pop_c})
            2'b10:   count_nxt_c = count + CNTW'(1);
            2'b01:   count_nxt_c = count - CNTW'(1);
            default: count_nxt_c = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            elem_cnt      <= '0;
            o_valid       <= 1'b0;
            o_almost_full <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            if (accept_c) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
            // Dropped elements still advance the element number, which keeps vectors aligned.
            if (push_c) elem_cnt <= last_c ? '0 : elem_cnt + VCNTW'(1);
            if (drop_c) o_overflow <= 1'b1;
            count         <= count_nxt_c;
            o_valid       <= (count_nxt_c != '0);
            o_almost_full <= (count_nxt_c >= CNTW'(FDEPTH - 3));
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) mem[wr_ptr] <= '{last: last_c, data: s2_data};
    end

    assign head_c = mem[rd_ptr];
    assign o_data = head_c.data;
    assign o_last = o_valid && head_c.last;

endmodule

// File: tb/tb_act_quant_stage.sv
// Directed bench for act_quant_stage: vector table for the arithmetic, plus hand sequences for
// tagging, backpressure, overflow, full push/pop and mid-vector reset.
module tb_act_quant_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_relu;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_last;
    logic        i_ready;
    logic        o_almost_full;
    logic        o_overflow;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [31:0] data;
        logic        relu;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    act_quant_stage dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_relu        (i_relu),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; reset is sampled on the next rising edge.
    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_o_valid", int'(o_valid), 0);
        chk("reset_o_last", int'(o_last), 0);
        chk("reset_o_almost_full", int'(o_almost_full), 0);
        chk("reset_o_overflow", int'(o_overflow), 0);
    endtask

    task automatic drain(input int n, input int base, input string tag);
        i_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_valid[%0d]", tag, k), int'(o_valid), 1);
            chk($sformatf("%s_data[%0d]", tag, k), int'(o_data), base + k);
            chk($sformatf("%s_last[%0d]", tag, k), int'(o_last), 0);
            @(negedge clk);
        end
    endtask

    // Stream n elements c*256 (quantizes to c, saturating at 127); offset is the element number of the first one.
    task automatic stream(input int n, input int offset);
        int idx   = 0;
        int first = -1;
        i_ready = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            @(negedge clk);
            if (o_valid) begin
                if (first < 0) first = c;
                chk($sformatf("stream_data[%0d]", idx), int'(o_data), (idx > 127) ? 127 : idx);
                chk($sformatf("stream_last[%0d]", idx), int'(o_last), (((idx + offset) % 64) == 63) ? 1 : 0);
                idx++;
            end
            if (c < n) begin
                i_valid = 1'b1;
                i_data  = 32'(c * 256);
                i_relu  = 1'b0;
            end else begin
                i_valid = 1'b0;
            end
        end
        chk("stream_first_valid_cycle", first, 3);
        chk("stream_count", idx, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'd4736,         1'b0, 8'h13};
        vecs[1]  = '{32'(-300),        1'b0, 8'hFF};
        vecs[2]  = '{32'd128,          1'b0, 8'h01};
        vecs[3]  = '{32'(-300),        1'b1, 8'h00};
        vecs[4]  = '{32'd65536,        1'b0, 8'h7F};
        vecs[5]  = '{32'(-65536),      1'b0, 8'h80};
        vecs[6]  = '{32'h7FFF_FFFF,    1'b0, 8'h7F};
        vecs[7]  = '{32'h7FFF_FFFF,    1'b1, 8'h7F};
        vecs[8]  = '{32'h8000_0000,    1'b0, 8'h80};
        vecs[9]  = '{32'h8000_0000,    1'b1, 8'h00};
        vecs[10] = '{32'd127,          1'b0, 8'h00};
        vecs[11] = '{32'(-129),        1'b0, 8'hFF};
        vecs[12] = '{32'(-128),        1'b0, 8'h00};
        vecs[13] = '{32'd32640,        1'b0, 8'h7F};
        vecs[14] = '{32'd32639,        1'b0, 8'h7F};
        vecs[15] = '{32'(-32896),      1'b0, 8'h80};
        vecs[16] = '{32'(-32897),      1'b0, 8'h80};
        vecs[17] = '{32'd32383,        1'b0, 8'h7E};

        i_valid = 1'b0;
        i_data  = '0;
        i_relu  = 1'b0;
        i_ready = 1'b0;
        rst     = 1'b1;

        // Arithmetic: one element at a time, output expected on the third negedge after driving.
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = vecs[i].data;
            i_relu  = vecs[i].relu;
            @(negedge clk);
            i_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early_valid", i), int'(o_valid), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), int'(o_valid), 1);
            chk($sformatf("vec%0d_data", i), int'(o_data), int'(vecs[i].exp));
            chk($sformatf("vec%0d_last", i), int'(o_last), 0);
        end

        // Vector tagging over 130 back-to-back elements.
        @(negedge clk);
        do_reset();
        stream(130, 0);

        // Backpressure: 13 elements reach the almost-full threshold without overflow.
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = 32'((c + 1) * 256);
            i_relu  = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk("bp_almost_full_at_12", int'(o_almost_full), 0);
        @(negedge clk);
        chk("bp_almost_full_at_13", int'(o_almost_full), 1);
        chk("bp_overflow", int'(o_overflow), 0);
        drain(13, 1, "bp");
        chk("bp_empty_valid", int'(o_valid), 0);
        chk("bp_empty_almost_full", int'(o_almost_full), 0);

        // Overflow: 18 pushes into a stalled FIFO, the last two are dropped but still numbered.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = 32'((c + 1) * 256);
            i_relu  = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_overflow", int'(o_overflow), 1);
        chk("ovf_almost_full", int'(o_almost_full), 1);
        chk("ovf_valid", int'(o_valid), 1);
        drain(16, 1, "ovf");
        chk("ovf_empty_valid", int'(o_valid), 0);
        chk("ovf_sticky_after_drain", int'(o_overflow), 1);
        stream(46, 18);
        chk("ovf_sticky_after_stream", int'(o_overflow), 1);

        // Full FIFO with a simultaneous push and pop.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = 32'((c + 1) * 256);
            i_relu  = 1'b0;
        end
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("full_almost_full", int'(o_almost_full), 1);
        chk("full_head", int'(o_data), 1);
        i_valid = 1'b1;
        i_data  = 32'(100 * 256);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("full_pushpop_overflow", int'(o_overflow), 0);
        chk("full_pushpop_head", int'(o_data), 2);
        chk("full_pushpop_almost_full", int'(o_almost_full), 1);
        drain(15, 2, "full");
        chk("full_tail_valid", int'(o_valid), 1);
        chk("full_tail_data", int'(o_data), 100);
        @(negedge clk);
        chk("full_empty_valid", int'(o_valid), 0);
        chk("full_final_overflow", int'(o_overflow), 0);

        // Mid-vector reset with one entry stored and one still in the pipeline.
        i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 32'(50 * 256);
        @(negedge clk);
        i_data  = 32'(60 * 256);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk("midrst_pre_valid", int'(o_valid), 1);
        chk("midrst_pre_data", int'(o_data), 50);
        do_reset();
        stream(64, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/act_quant_stage.md
# act_quant_stage

Post-accumulation output stage for the MVM datapath. It sits directly downstream of the accumulator and takes each finished vector element on the accumulator's valid/result pair. For each element it applies optional ReLU, then a rounding arithmetic right shift, then signed saturation to the narrower activation width. Results are buffered in a FIFO and presented to the next layer's loader through a valid/ready handshake, with an end-of-vector tag.

## Interface
- IDATAW, 32, input (accumulator result) width, signed two's complement
- ODATAW, 8, output activation width, signed; 2 ≤ ODATAW < IDATAW
- SHIFT, 8, requantization right-shift amount; 1 ≤ SHIFT < IDATAW
- FDEPTH, 16, output FIFO depth in entries; must be at least 4
- FADDRW, 4, $clog2(FDEPTH)
- VECLEN, 64, elements per output vector
- VCNTW, 6, $clog2(VECLEN)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input element valid, one element per cycle; there is no backpressure
- i_data  in  IDATAW  accumulated sum, signed
- i_relu  in  1  apply ReLU to this element; sampled together with i_valid
- o_valid  out  1  FIFO head is valid
- o_data  out  ODATAW  quantized activation at the FIFO head
- o_last  out  1  FIFO head is element VECLEN-1 of its vector
- i_ready  in  1  downstream accepts the head; a pop happens when o_valid && i_ready
- o_almost_full  out  1  FIFO occupancy ≥ FDEPTH-3; upstream must stop issuing
- o_overflow  out  1  sticky flag; an element was dropped because the FIFO was full

## Operation
- Stage 1 (register): if i_relu and i_data is negative, the value is 0; otherwise the value is i_data.
- Stage 2 (register): compute t = (v + 2^(SHIFT-1)) >>> SHIFT in IDATAW+1 bits.
  - This is round-half-up toward +inf, and the sum cannot overflow.
  - Saturate t to [-2^(ODATAW-1), 2^(ODATAW-1)-1].
- Element counter:
  - Increments on every stage-2 valid, including elements that are dropped, so vector alignment is preserved.
  - Wraps from VECLEN-1 to 0.
  - The element at count VECLEN-1 is written with last=1.
- FIFO: circular buffer of {last, data} entries with write pointer, read pointer and an occupancy count of FADDRW+1 bits.
  - o_valid = (count != 0).
  - o_data and o_last are read combinationally from the entry at the read pointer.
- Simultaneous push and pop:
  - Count is unchanged.
  - Allowed when full, because the pop frees a slot and the push is accepted.
  - Allowed when empty, where only the push takes effect because o_valid=0 means no pop.
- Push while full with no pop: the element is dropped, o_overflow is set, and the pointers and count are unchanged.
- Pointers wrap from FDEPTH-1 to 0; FDEPTH is not required to be a power of two.
- Reset behaviour:
  - Clears both pipeline stages' valid bits, both pointers, the count, the element counter and o_overflow.
  - Any element in flight is discarded.
  - Reset asserted mid-vector restarts element numbering at 0.

## Timing
- Reset values: o_valid=0, o_last=0, o_almost_full=0, o_overflow=0. o_data is don't-care while o_valid=0.
- Latency with an empty FIFO: i_valid high in cycle 0 gives o_valid high in cycle 3, with o_data valid in the same cycle.
- Throughput is one element per cycle, both in and out.
- Within a cycle, o_valid, o_data and o_last hold stable until a pop occurs.
- The head advances on the edge where o_valid && i_ready is true.
- o_almost_full derives from the registered count.
  - Its threshold covers the 2 in-flight pipeline stages plus 1 cycle of upstream reaction.
  - An upstream that honours it never causes overflow.
- o_overflow is set on the edge of the dropping write. It stays high until rst.

## Test plan
- Rounding and sign, with SHIFT=8, ODATAW=8, i_relu=0:
  - i_data=4736 → o_data=0x13 (18.5 rounds to 19).
  - i_data=-300 → o_data=0xFF.
  - i_data=128 → o_data=0x01.
- ReLU and saturation:
  - i_data=-300 with i_relu=1 → 0x00.
  - 65536 → 0x7F.
  - -65536 → 0x80.
  - 0x7FFFFFFF → 0x7F, with no wrap in the rounding add.
- Vector tagging: stream 130 back-to-back elements with i_ready=1 → o_last=1 on exactly output indices 63 and 127, and 0 elsewhere. The first o_valid appears in cycle 3.
- Backpressure: hold i_ready=0 and push 13 elements → o_almost_full rises when count reaches 13, there is no overflow, and the 13 entries drain in order once i_ready=1.
- Overflow: hold i_ready=0 and push 18 elements → 16 are stored and the 17th and 18th are dropped. o_overflow=1 and stays at 1 after draining. Element numbering still counts the dropped pair.
- Full simultaneous push/pop, then reset: with the FIFO full, push and pop in the same cycle → count stays 16 and o_overflow stays 0. Asserting rst mid-vector for 1 cycle → o_valid=0 on the following cycle. The next 64 inputs produce o_last only on the 64th.
